// File: rtl/ps2_link_ctrl_pkg.sv
// Shared constants and helpers for the PS/2 host link controller.
package ps2_link_ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_RX        = 3'd1;
  localparam state_t ST_INHIBIT   = 3'd2;
  localparam state_t ST_RTS       = 3'd3;
  localparam state_t ST_TX        = 3'd4;
  localparam state_t ST_ACK       = 3'd5;
  localparam state_t ST_WAIT_IDLE = 3'd6;

  localparam int FRAME_BITS = 11;
  localparam int TMR_W      = 16;

  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

  function automatic int us_tick_div(input int clk_freq_hz);
    return clk_freq_hz / 1_000_000;
  endfunction

endpackage

// File: rtl/ps2_link_ctrl_if.sv
// Byte-level handshake between the PS/2 link controller and the keyboard logic.
interface ps2_link_ctrl_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_nak;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_err;
  logic       busy;

  modport master (
    output tx_valid, tx_data,
    input  tx_ready, tx_done, tx_nak, rx_valid, rx_data, rx_err, busy
  );

  modport slave (
    input  tx_valid, tx_data,
    output tx_ready, tx_done, tx_nak, rx_valid, rx_data, rx_err, busy
  );
endinterface

// File: rtl/ps2_link_ctrl_edge_sync.sv
// Two-flop synchronizer for one PS/2 pad line with a falling-edge strobe.
module ps2_link_ctrl_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic line,
  output logic level,
  output logic fall
);
  logic [1:0] sync;
  logic       prev;

  // Reset to the idle-high bus level so release never fakes an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 2'b11;
      prev <= 1'b1;
    end else begin
      sync <= {sync[0], line};
      prev <= sync[1];
    end
  end

  assign level = sync[1];
  assign fall  = prev & ~sync[1];
endmodule

// File: rtl/ps2_link_ctrl.sv
// PS/2 host-side link controller: owns the open-drain clk/data pair,
// receives device frames and sequences host-to-device commands.
module ps2_link_ctrl
  import ps2_link_ctrl_pkg::*;
#(
  parameter int CLK_FREQ_HZ      = 50_000_000,
  parameter int INHIBIT_US       = 100,
  parameter int BIT_TIMEOUT_US   = 200,
  parameter int START_TIMEOUT_US = 15000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk_i,
  input  logic ps2_dat_i,
  output logic ps2_clk_oe,
  output logic ps2_dat_oe,
  ps2_link_ctrl_if.slave host
);
  localparam int TICK_DIV = us_tick_div(CLK_FREQ_HZ);
  localparam int PRE_W    = $clog2(TICK_DIV + 1);
  localparam logic [PRE_W-1:0] PRE_MAX   = PRE_W'(TICK_DIV - 1);
  localparam logic [TMR_W-1:0] INHIBIT_T = TMR_W'(INHIBIT_US);
  localparam logic [TMR_W-1:0] BIT_T     = TMR_W'(BIT_TIMEOUT_US);
  localparam logic [TMR_W-1:0] START_T   = TMR_W'(START_TIMEOUT_US);

  logic clk_lvl, clk_fall, dat_lvl, dat_fall_unused;

  ps2_link_ctrl_edge_sync u_clk_sync (
    .clk(clk), .rst_n(rst_n), .line(ps2_clk_i), .level(clk_lvl), .fall(clk_fall)
  );
  ps2_link_ctrl_edge_sync u_dat_sync (
    .clk(clk), .rst_n(rst_n), .line(ps2_dat_i), .level(dat_lvl), .fall(dat_fall_unused)
  );

  logic [PRE_W-1:0] pre_cnt;
  logic             us_tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       pre_cnt <= PRE_MAX;
    else if (us_tick) pre_cnt <= PRE_MAX;
    else              pre_cnt <= pre_cnt - 1'b1;
  end
  assign us_tick = (pre_cnt == '0);

  state_t           state;
  logic [3:0]       bit_cnt;
  logic [8:0]       shreg;
  logic [7:0]       tx_byte;
  logic [TMR_W-1:0] timer;
  logic             tmr_zero;
  logic             idle_arm;
  logic [7:0]       rx_data;
  logic             rx_valid, rx_err, tx_done, tx_nak;

  assign tmr_zero = (timer == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      tx_byte  <= '0;
      timer    <= '0;
      idle_arm <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      tx_done  <= 1'b0;
      tx_nak   <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      tx_done  <= 1'b0;
      tx_nak   <= 1'b0;
      if (us_tick && !tmr_zero) timer <= timer - 1'b1;
      if (state != ST_WAIT_IDLE) idle_arm <= 1'b0;
      case (state)
        ST_IDLE: begin
          // A device start bit always wins over a pending host byte.
          if (clk_fall) begin
            if (!dat_lvl) begin
              state   <= ST_RX;
              bit_cnt <= 4'd1;
              timer   <= BIT_T;
            end
          end else if (host.tx_valid && clk_lvl) begin
            tx_byte <= host.tx_data;
            state   <= ST_INHIBIT;
            timer   <= INHIBIT_T;
          end
        end
        ST_RX: begin
          if (clk_fall) begin
            timer <= BIT_T;
            if (bit_cnt == 4'(FRAME_BITS - 1)) begin
              rx_valid <= 1'b1;
              rx_data  <= shreg[7:0];
              rx_err   <= (shreg[8] != odd_parity(shreg[7:0])) || !dat_lvl;
              state    <= ST_WAIT_IDLE;
            end else begin
              shreg   <= {dat_lvl, shreg[8:1]};
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (tmr_zero) begin
            rx_valid <= 1'b1;
            rx_err   <= 1'b1;
            state    <= ST_WAIT_IDLE;
          end
        end
        ST_INHIBIT: begin
          if (tmr_zero) begin
            state <= ST_RTS;
            timer <= START_T;
          end
        end
        ST_RTS: begin
          if (clk_fall) begin
            state   <= ST_TX;
            bit_cnt <= 4'd0;
            timer   <= BIT_T;
          end else if (tmr_zero) begin
            tx_done <= 1'b1;
            tx_nak  <= 1'b1;
            state   <= ST_WAIT_IDLE;
          end
        end
        ST_TX: begin
          if (clk_fall) begin
            timer <= BIT_T;
            if (bit_cnt == 4'd8) state   <= ST_ACK;
            else                 bit_cnt <= bit_cnt + 1'b1;
          end else if (tmr_zero) begin
            tx_done <= 1'b1;
            tx_nak  <= 1'b1;
            state   <= ST_WAIT_IDLE;
          end
        end
        ST_ACK: begin
          if (clk_fall || tmr_zero) begin
            tx_done <= 1'b1;
            tx_nak  <= clk_fall ? dat_lvl : 1'b1;
            state   <= ST_WAIT_IDLE;
          end
        end
        ST_WAIT_IDLE: begin
          // Arm on one tick with both lines high, leave on the next.
          if (!(clk_lvl && dat_lvl)) idle_arm <= 1'b0;
          else if (us_tick) begin
            if (idle_arm) state    <= ST_IDLE;
            else          idle_arm <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    ps2_clk_oe = (state == ST_INHIBIT);
    ps2_dat_oe = 1'b0;
    if (state == ST_RTS)
      ps2_dat_oe = 1'b1;
    else if (state == ST_TX)
      ps2_dat_oe = (bit_cnt == 4'd8) ? ~odd_parity(tx_byte) : ~tx_byte[bit_cnt[2:0]];
  end

  assign host.tx_ready = (state == ST_IDLE) && !clk_fall && clk_lvl && host.tx_valid;
  assign host.tx_done  = tx_done;
  assign host.tx_nak   = tx_nak;
  assign host.rx_valid = rx_valid;
  assign host.rx_data  = rx_data;
  assign host.rx_err   = rx_err;
  assign host.busy     = (state != ST_IDLE);
endmodule

// File: tb/tb_ps2_link_ctrl.sv
// Bench for ps2_link_ctrl: bus-level device model plus a queue scoreboard on rx/tx results.
`timescale 1ns/1ps
module tb_ps2_link_ctrl;
  localparam int CLK_HZ = 2_000_000;

  typedef struct packed {
    logic [7:0] data;
    logic       err;
  } rx_exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;
  logic clk_oe, dat_oe;
  logic ps2_clk_line, ps2_dat_line;

  assign ps2_clk_line = ~(dev_clk_low | clk_oe);
  assign ps2_dat_line = ~(dev_dat_low | dat_oe);

  ps2_link_ctrl_if host();

  ps2_link_ctrl #(.CLK_FREQ_HZ(CLK_HZ)) dut (
    .clk(clk), .rst_n(rst_n),
    .ps2_clk_i(ps2_clk_line), .ps2_dat_i(ps2_dat_line),
    .ps2_clk_oe(clk_oe), .ps2_dat_oe(dat_oe),
    .host(host)
  );

  always #250 clk = ~clk;

  rx_exp_t exp_rx[$];
  logic    exp_tx[$];
  int      n_pass = 0;
  int      n_total = 0;
  time     last_rx_t = 0;
  time     last_fall_t = 0;
  time     oe_rise_t = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  always @(posedge clk_oe) oe_rise_t = $time;

  always @(negedge clk) begin
    if (rst_n) begin
      if (host.rx_valid) begin
        rx_exp_t e;
        last_rx_t = $time;
        check("rx_expected", exp_rx.size() != 0, 1);
        if (exp_rx.size() != 0) begin
          e = exp_rx.pop_front();
          check("rx_data", host.rx_data, e.data);
          check("rx_err", host.rx_err, e.err);
        end
      end
      if (host.tx_done) begin
        logic n;
        check("tx_expected", exp_tx.size() != 0, 1);
        if (exp_tx.size() != 0) begin
          n = exp_tx.pop_front();
          check("tx_nak", host.tx_nak, n);
        end
      end
    end
  end

  // Device-to-host frame, only the first nedges bits are clocked out.
  task automatic send_frame(input logic [7:0] d, input logic flip_par, input int nedges);
    logic [10:0] f;
    f = {1'b1, (~^d) ^ flip_par, d, 1'b0};
    for (int i = 0; i < nedges; i++) begin
      dev_dat_low = ~f[i];
      #10us;
      @(negedge clk);
      dev_clk_low = 1'b1;
      last_fall_t = $time;
      #40us;
      dev_clk_low = 1'b0;
      #30us;
    end
    dev_dat_low = 1'b0;
  endtask

  task automatic host_send(input logic [7:0] d, output time acc_t);
    int n = 0;
    host.tx_valid = 1'b1;
    host.tx_data  = d;
    #1;
    while (!host.tx_ready && n < 8000) begin
      @(negedge clk);
      n++;
    end
    check("tx_accept", host.tx_ready, 1);
    acc_t = $time;
    @(posedge clk);
    #1;
    host.tx_valid = 1'b0;
  endtask

  // Inhibit then request-to-send: clk held low >= 100 us, data low at release.
  task automatic wait_rts();
    int n = 0;
    while (!clk_oe && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("inhibit_start", clk_oe, 1);
    n = 0;
    while (clk_oe && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("inhibit_end", clk_oe, 0);
    check("inhibit_len_ok", (($time - oe_rise_t) >= 100_000) && (($time - oe_rise_t) <= 101_000), 1);
    check("rts_data_low", dat_oe, 1);
  endtask

  task automatic dev_accept(input logic [7:0] exp_byte, input logic exp_par);
    logic [9:0] bits;
    bits = '0;
    wait_rts();
    #50us;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      dev_clk_low = 1'b1;
      #33us;
      dev_clk_low = 1'b0;
      #1;
      bits[i] = ps2_dat_line;
      #32us;
    end
    check("tx_byte", bits[7:0], exp_byte);
    check("tx_parity", bits[8], exp_par);
    check("tx_stop", bits[9], 1);
    dev_dat_low = 1'b1;
    #10us;
    @(negedge clk);
    dev_clk_low = 1'b1;
    #33us;
    dev_clk_low = 1'b0;
    #20us;
    dev_dat_low = 1'b0;
  endtask

  initial begin
    #40ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    time t_acc, t_ref, t6_start;
    int  n;
    host.tx_valid = 1'b0;
    host.tx_data  = 8'h00;
    repeat (5) @(negedge clk);
    check("rst_clk_oe", clk_oe, 0);
    check("rst_dat_oe", dat_oe, 0);
    check("rst_busy", host.busy, 0);
    check("rst_rx_valid", host.rx_valid, 0);
    check("rst_rx_data", host.rx_data, 0);
    check("rst_tx_done", host.tx_done, 0);
    check("rst_tx_ready", host.tx_ready, 0);
    rst_n = 1'b1;
    #20us;

    // Good frame 0xA5
    exp_rx.push_back(rx_exp_t'({8'hA5, 1'b0}));
    send_frame(8'hA5, 1'b0, 11);
    #10us;
    check("busy_after_a5", host.busy, 0);

    // Parity error on 0x3C
    #100us;
    exp_rx.push_back(rx_exp_t'({8'h3C, 1'b1}));
    send_frame(8'h3C, 1'b1, 11);
    #10us;
    check("busy_after_3c", host.busy, 0);

    // Device stalls after 4 bits of 0xFF: timeout, rx_data keeps 0x3C
    #100us;
    exp_rx.push_back(rx_exp_t'({8'h3C, 1'b1}));
    send_frame(8'hFF, 1'b0, 4);
    n = 0;
    while (!host.rx_valid && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("rx_timeout_seen", host.rx_valid, 1);
    check("rx_timeout_gap_ok", (($time - last_fall_t) >= 195_000) && (($time - last_fall_t) <= 210_000), 1);
    #20us;
    check("busy_after_timeout", host.busy, 0);

    // Host sends 0xED, device clocks at ~15 kHz and acks
    #100us;
    exp_tx.push_back(1'b0);
    host_send(8'hED, t_acc);
    dev_accept(8'hED, 1'b1);
    #20us;
    check("busy_after_ed", host.busy, 0);

    // Host sends 0xF4, device never clocks: abort after start timeout
    #100us;
    exp_tx.push_back(1'b1);
    host_send(8'hF4, t_acc);
    wait_rts();
    t_ref = $time;
    n = 0;
    while (!host.tx_done && n < 32000) begin
      @(negedge clk);
      n++;
    end
    check("abort_done_seen", host.tx_done, 1);
    check("abort_time_ok", (($time - t_ref) >= 14_990_000) && (($time - t_ref) <= 15_010_000), 1);
    check("abort_clk_oe", clk_oe, 0);
    check("abort_dat_oe", dat_oe, 0);
    #20us;

    // tx_valid lands in the start-edge cycle of 0x1C: receive first, then send 0x55
    #100us;
    exp_rx.push_back(rx_exp_t'({8'h1C, 1'b0}));
    exp_tx.push_back(1'b0);
    t6_start = $time;
    fork
      begin
        send_frame(8'h1C, 1'b0, 11);
        dev_accept(8'h55, 1'b1);
      end
      begin
        wait (dev_clk_low == 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        host.tx_valid = 1'b1;
        host.tx_data  = 8'h55;
        #1;
        check("tx_ready_on_rx_edge", host.tx_ready, 0);
        host_send(8'h55, t_acc);
        check("tx_after_rx", (t_acc > last_rx_t) && (last_rx_t > t6_start), 1);
      end
    join
    #20us;

    // Reset during bit 4 of 0x0F: bus released at once, no completion
    #100us;
    host_send(8'h0F, t_acc);
    wait_rts();
    #50us;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      dev_clk_low = 1'b1;
      #33us;
      dev_clk_low = 1'b0;
      #32us;
    end
    @(negedge clk);
    dev_clk_low = 1'b1;
    #10us;
    check("tx_bit4_driven", dat_oe, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_clk_oe", clk_oe, 0);
    check("rst_mid_dat_oe", dat_oe, 0);
    check("rst_mid_busy", host.busy, 0);
    dev_clk_low = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    #300us;
    check("post_rst_busy", host.busy, 0);

    check("rx_queue_empty", exp_rx.size(), 0);
    check("tx_queue_empty", exp_tx.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/ps2_link_ctrl.md
Name: ps2_link_ctrl

Overview:
Host-side controller for a PS/2 clock/data pair: the single owner and sequencer of the open-drain bus.
- Receives device-to-host frames: start 0, 8 data bits LSB first, odd parity (~^data), stop 1, sampled on device clock falling edges.
- Arbitrates bus direction: a pending host command waits for the line to be free, then runs the inhibit / request-to-send / transmit / ack sequence.
- Sits between the pad-level open-drain buffers and the byte-level keyboard logic.

Parameters:
CLK_FREQ_HZ, 50_000_000, system clock frequency; must be an integer multiple of 1 MHz.
INHIBIT_US, 100, duration clk is held low before request-to-send.
BIT_TIMEOUT_US, 200, maximum gap between device clock falling edges inside a frame.
START_TIMEOUT_US, 15000, maximum wait for the first device clock falling edge after request-to-send.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
ps2_clk_i  in  1  raw PS/2 clock from pad (asynchronous)
ps2_dat_i  in  1  raw PS/2 data from pad (asynchronous)
ps2_clk_oe  out  1  1 = pull PS/2 clock low
ps2_dat_oe  out  1  1 = pull PS/2 data low
tx_valid  in  1  host byte pending
tx_data  in  8  host byte
tx_ready  out  1  byte accepted this cycle (valid & ready)
tx_done  out  1  1-cycle pulse: transmit finished
tx_nak  out  1  qualifies tx_done: ack missing or timeout
rx_valid  out  1  1-cycle pulse: frame received
rx_data  out  8  received byte, held until next rx_valid
rx_err  out  1  qualifies rx_valid: parity, start/stop or timeout error
busy  out  1  state != IDLE

Behaviour:
- Reset (async assert, sync release): state IDLE, all outputs 0, rx_data 0. Both oe are 0, so the bus is released.
- Input sync: each ps2 input passes through a 2-FF synchronizer. Falling edge = sync_prev 1 & sync 0.
  - Latency is 3 clk from pad edge to internal edge strobe.
  - All line samples use the synchronized data at the edge strobe.
- us_tick: prescaler pulse every CLK_FREQ_HZ/1e6 clk. Timers count us_tick and reset on state entry or any clock falling edge.
- States: IDLE, RX, INHIBIT, RTS, TX, ACK, WAIT_IDLE.
- IDLE:
  - Clock falling edge with data 0 -> RX, bit count 1.
  - Clock falling edge with data 1 is ignored (glitch).
  - Otherwise, if tx_valid and synchronized clock is high: assert tx_ready for exactly 1 cycle, latch tx_data, go to INHIBIT.
  - RX has priority: an edge strobe and tx_valid in the same cycle -> RX, tx_ready stays 0.
- RX:
  - Shift data on each falling edge until 11 bits are taken.
  - On the 11th edge: rx_valid=1 for 1 cycle, rx_data = bits 1..8.
  - rx_err=1 if parity != ~^data or stop == 0. The data byte is still delivered.
  - BIT_TIMEOUT_US without an edge: rx_valid=1, rx_err=1, rx_data unchanged.
  - After either outcome -> WAIT_IDLE.
- INHIBIT: ps2_clk_oe=1 for INHIBIT_US ticks, then -> RTS.
- RTS:
  - ps2_dat_oe=1 (start bit), ps2_clk_oe=0.
  - First falling edge: drive d0, bit count 0 -> TX.
  - START_TIMEOUT_US without an edge -> abort.
- TX:
  - Each falling edge advances to d1..d7, then parity (~^tx_byte).
  - ps2_dat_oe = ~bit.
  - Edge after parity: release data (stop) -> ACK.
  - Any gap of BIT_TIMEOUT_US -> abort.
- ACK:
  - Next falling edge samples data: 0 gives tx_done with tx_nak=0; 1 gives tx_done with tx_nak=1.
  - Timeout -> abort.
  - Either way -> WAIT_IDLE.
- Abort: release both oe, pulse tx_done with tx_nak=1, go to WAIT_IDLE.
- WAIT_IDLE:
  - oe=0.
  - Leave to IDLE once clk and data are both sync-high for 1 full us_tick period.
  - No timeout.
- Reset mid-operation releases the bus immediately. No tx_done or rx_valid is issued for the interrupted transfer.
- tx_ready never asserts outside IDLE. At most one byte is in flight.

Decomposition:
- ps2_pkg:
  - state enum typedef.
  - FRAME_BITS=11.
  - odd_parity function.
  - us-tick divisor calculation.
- Sub-module ps2_edge_sync: 2-FF synchronizer + falling-edge strobe. Instantiated once per line; the edge output is used only for clk.

Test Plan:
- Device sends 0xA5, correct parity 1, at 12 kHz -> one rx_valid, rx_data=0xA5, rx_err=0, busy low after stop.
- Device sends 0x3C with parity flipped -> rx_valid, rx_data=0x3C, rx_err=1.
- Device stops clocking after 4 bits of 0xFF -> rx_valid, rx_err=1, ~200 us after the last edge, rx_data unchanged.
- Host tx_data=0xED, bench model clocks at 15 kHz and acks:
  - clk held low ≥100 us, data low at release.
  - Bench decodes 0xED with parity 1 and stop 1.
  - tx_done=1, tx_nak=0.
- Host 0xF4, bench never clocks -> tx_done, tx_nak=1 at 15 ms, both oe=0.
- tx_valid raised in the same cycle as a device start-bit edge -> receive of 0x1C completes first. Then tx_ready is asserted and 0x1C's successor command is sent. Also: assert reset during TX bit 4 -> oe=0 within 1 clk, no tx_done.
